// File: rtl/tube_pkg.sv
// Shared constants for the seven-segment tube driver: register map,
// active-low segment lookup and the all-dark pattern.
package tube_pkg;

    localparam logic [1:0] TUBE_ADDR_LOW  = 2'd0;
    localparam logic [1:0] TUBE_ADDR_HIGH = 2'd1;
    localparam logic [1:0] TUBE_ADDR_CTRL = 2'd2;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Index 0 is the rightmost entry; codes are {dp,g..a}, dp off.
    localparam logic [15:0][7:0] SEG_LUT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,
        8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99,
        8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/tube_display_controller_if.sv
// CPU-side write port of the tube driver; the CPU is the master,
// the display controller the slave. The port is write-only.
interface tube_display_controller_if;

    logic        iDoTubeWrite;
    logic [1:0]  iTubeAddress;
    logic [15:0] iTubeDataToWrite;

    modport master (
        output iDoTubeWrite,
        output iTubeAddress,
        output iTubeDataToWrite
    );

    modport slave (
        input iDoTubeWrite,
        input iTubeAddress,
        input iTubeDataToWrite
    );

endinterface

// File: rtl/hex_to_seven_segment.sv
// Combinational hex nibble to active-low {dp,g..a} segment byte.
module hex_to_seven_segment
    import tube_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] segments
);

    logic [7:0] code;

    assign code     = SEG_LUT[nibble];
    assign segments = {code[7] & ~dp, code[6:0]};

endmodule

// File: rtl/tube_display_controller.sv
// Memory-mapped 8-digit common-anode tube driver with free-running scan.
// Optional build macro: TUBE_LEADING_ZERO_BLANK_EN blanks leading zeros.
module tube_display_controller
    import tube_pkg::*;
#(
    parameter int SCAN_DIVIDE = 20000
) (
    input  logic                      iCpuClock,
    input  logic                      iCpuReset,
    tube_display_controller_if.slave  tubeBus,
    output logic [7:0]                oTubeSegments,
    output logic [7:0]                oTubeEnables
);

    localparam int CNT_W = (SCAN_DIVIDE > 2) ? $clog2(SCAN_DIVIDE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIVIDE - 1);

    logic [15:0]      dataLow;
    logic [15:0]      dataHigh;
    logic [7:0]       dpMask;
    logic             dispEn;
    logic [CNT_W-1:0] scanCnt;
    logic [2:0]       digitIdx;

    logic [31:0] dataAll;
    logic [4:0]  bitBase;
    logic [3:0]  curNibble;
    logic        curDp;
    logic        blank;
    logic [7:0]  decoded;
    logic        wrLow;
    logic        wrHigh;
    logic        wrCtrl;

    assign wrLow  = tubeBus.iDoTubeWrite
                 && (tubeBus.iTubeAddress == TUBE_ADDR_LOW);
    assign wrHigh = tubeBus.iDoTubeWrite
                 && (tubeBus.iTubeAddress == TUBE_ADDR_HIGH);
    assign wrCtrl = tubeBus.iDoTubeWrite
                 && (tubeBus.iTubeAddress == TUBE_ADDR_CTRL);

    always_ff @(posedge iCpuClock or posedge iCpuReset) begin
        if (iCpuReset) begin
            dataLow  <= '0;
            dataHigh <= '0;
            dpMask   <= '0;
            dispEn   <= 1'b0;
        end else begin
            unique case (1'b1)
                wrLow:  dataLow  <= tubeBus.iTubeDataToWrite;
                wrHigh: dataHigh <= tubeBus.iTubeDataToWrite;
                wrCtrl: begin
                    dpMask <= tubeBus.iTubeDataToWrite[15:8];
                    dispEn <= tubeBus.iTubeDataToWrite[0];
                end
                default: ;
            endcase
        end
    end

    // Scan keeps running while disabled so re-enabling resumes in place.
    always_ff @(posedge iCpuClock or posedge iCpuReset) begin
        if (iCpuReset) begin
            scanCnt  <= '0;
            digitIdx <= '0;
        end else if (scanCnt == CNT_LAST) begin
            scanCnt  <= '0;
            digitIdx <= digitIdx + 3'd1;
        end else begin
            scanCnt <= scanCnt + 1'b1;
        end
    end

    assign dataAll   = {dataHigh, dataLow};
    assign bitBase   = {digitIdx, 2'b00};
    assign curNibble = dataAll[bitBase +: 4];
    assign curDp     = dpMask[digitIdx];

`ifdef TUBE_LEADING_ZERO_BLANK_EN
    logic [31:0] upperDigits;

    assign upperDigits = dataAll >> bitBase;
    assign blank       = (digitIdx != 3'd0) && (upperDigits == 32'd0);
`else
    assign blank = 1'b0;
`endif

    hex_to_seven_segment u_hex (
        .nibble   (curNibble),
        .dp       (curDp),
        .segments (decoded)
    );

    always_ff @(posedge iCpuClock or posedge iCpuReset) begin
        if (iCpuReset) begin
            oTubeSegments <= SEG_OFF;
            oTubeEnables  <= SEG_OFF;
        end else if (dispEn) begin
            oTubeEnables  <= ~(8'd1 << digitIdx);
            oTubeSegments <= blank ? {~curDp, 7'h7F} : decoded;
        end else begin
            oTubeSegments <= SEG_OFF;
            oTubeEnables  <= SEG_OFF;
        end
    end

endmodule

// File: tb/tb_tube_display_controller.sv
// Scoreboard bench for tube_display_controller: random and directed
// writes against a frame-level reference model, SCAN_DIVIDE = 4.
module tb_tube_display_controller;

    localparam int D = 4;

    typedef struct {
        logic [7:0] seg;
        logic [7:0] en;
        int         edgeNo;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] segs;
    logic [7:0] ens;

    tube_display_controller_if bus();

    tube_display_controller #(.SCAN_DIVIDE(D)) dut (
        .iCpuClock     (clk),
        .iCpuReset     (rst),
        .tubeBus       (bus),
        .oTubeSegments (segs),
        .oTubeEnables  (ens)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] segTab [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    int          edgeCnt = 0;
    logic [15:0] mLow = '0;
    logic [15:0] mHigh = '0;
    logic [15:0] mCtrl = '0;

    // Outputs after an edge show the register state and digit before it.
    function automatic exp_t model();
        exp_t        e;
        int          digit;
        int          msd;
        logic [31:0] full;
        logic [3:0]  nib;
        logic        dp;
        digit    = (edgeCnt / D) % 8;
        full     = {mHigh, mLow};
        e.edgeNo = edgeCnt;
        if (mCtrl[0] == 1'b0) begin
            e.seg = 8'hFF;
            e.en  = 8'hFF;
            return e;
        end
        msd = 0;
        for (int i = 0; i < 8; i++)
            if (((full >> (4 * i)) & 32'hF) != 0) msd = i;
        nib   = 4'((full >> (4 * digit)) & 32'hF);
        dp    = mCtrl[8 + digit];
        e.en  = 8'hFF ^ (8'd1 << digit);
        e.seg = segTab[nib];
`ifdef TUBE_LEADING_ZERO_BLANK_EN
        if (digit > msd) e.seg = 8'hFF;
`endif
        if (dp) e.seg = e.seg & 8'h7F;
        return e;
    endfunction

    // Called at a negedge; leaves the bench at the following negedge.
    task automatic step(input bit we, input logic [1:0] a,
                        input logic [15:0] d);
        q.push_back(model());
        bus.iDoTubeWrite     = we;
        bus.iTubeAddress     = a;
        bus.iTubeDataToWrite = d;
        if (we) begin
            case (a)
                2'd0: mLow = d;
                2'd1: mHigh = d;
                2'd2: mCtrl = d & 16'hFF01;
                default: ;
            endcase
        end
        edgeCnt++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 2'($urandom), 16'($urandom));
    endtask

    task automatic checkDark(input string tag);
        tests++;
        if (segs !== 8'hFF || ens !== 8'hFF) begin
            fails++;
            $display("FAIL %s: seg=%h en=%h, want FF/FF", tag, segs, ens);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && q.size() > 0) begin
                e = q.pop_front();
                tests++;
                if (segs !== e.seg || ens !== e.en) begin
                    fails++;
                    $display("FAIL out@edge%0d: seg=%h en=%h, want %h/%h",
                             e.edgeNo, segs, ens, e.seg, e.en);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [15:0] d;
        logic [1:0]  a;
        rst                  = 1'b0;
        bus.iDoTubeWrite     = 1'b0;
        bus.iTubeAddress     = '0;
        bus.iTubeDataToWrite = '0;
        #2 rst = 1'b1;
        #1 checkDark("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        idle(40);
        step(1'b1, 2'd0, 16'h4321);
        step(1'b1, 2'd1, 16'h8765);
        step(1'b1, 2'd2, 16'h0001);
        idle(40);
        step(1'b1, 2'd0, 16'h0000);
        step(1'b1, 2'd2, 16'h0101);
        idle(36);
        step(1'b1, 2'd3, 16'hFFFF);
        idle(36);
        idle(5);
        step(1'b1, 2'd2, 16'h0000);
        idle(7);
        step(1'b1, 2'd2, 16'h0001);
        idle(20);
        step(1'b1, 2'd0, 16'h0042);
        step(1'b1, 2'd1, 16'h0000);
        idle(34);
        step(1'b1, 2'd0, 16'h0000);
        idle(34);

        for (int i = 0; i < 500; i++) begin
            a = 2'($urandom);
            case ($urandom % 3)
                0:       d = 16'($urandom);
                1:       d = 16'($urandom) & 16'h00FF;
                default: d = 16'h0000;
            endcase
            if (a == 2'd2) d[0] = (($urandom % 4) != 0);
            step(($urandom % 4) == 0, a, d);
        end

        step(1'b1, 2'd0, 16'hA5C3);
        step(1'b1, 2'd2, 16'hFF01);
        idle(6);
        rst = 1'b1;
        #1 checkDark("midreset");
        bus.iDoTubeWrite = 1'b0;
        mLow    = '0;
        mHigh   = '0;
        mCtrl   = '0;
        edgeCnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(4);
        step(1'b1, 2'd1, 16'h00B0);
        step(1'b1, 2'd2, 16'h0201);
        idle(40);

        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d pending, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
